// File: rtl/ycc_block_ctrl_pkg.sv
// Shared types for the RGB block controller:
// FSM states, block size and pixel type.
package ycc_block_ctrl_pkg;

    localparam int BLK_PIX = 64;

    typedef logic [7:0] pix_t;

    typedef enum logic [1:0] {
        FILL,
        CONV,
        HOLD
    } state_t;

endpackage

// File: rtl/ycc_pix_buf.sv
// 64-entry RGB pixel store, all entries visible in parallel.
// Contents are not reset; every entry is rewritten before use.
module ycc_pix_buf
    import ycc_block_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      we,
    input  logic [5:0]                idx,
    input  logic [23:0]               din,
    output logic [BLK_PIX-1:0][7:0]   q_r,
    output logic [BLK_PIX-1:0][7:0]   q_g,
    output logic [BLK_PIX-1:0][7:0]   q_b
);

    logic [BLK_PIX-1:0][23:0] mem_q;
    logic [BLK_PIX-1:0][23:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[idx] = din;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int k = 0; k < BLK_PIX; k++) begin
            q_r[k] = mem_q[k][23:16];
            q_g[k] = mem_q[k][15:8];
            q_b[k] = mem_q[k][7:0];
        end
    end

endmodule

// File: rtl/ycc_block_ctrl.sv
// Collects an 8x8 RGB block, launches the luma converter,
// then holds the block until the consumer takes it.
module ycc_block_ctrl
    import ycc_block_ctrl_pkg::*;
#(
    parameter int CONV_LAT  = 2,
    parameter int BLK_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    input  logic [7:0]              pix_r,
    input  logic [7:0]              pix_g,
    input  logic [7:0]              pix_b,
    output logic [BLK_PIX-1:0][7:0] buf_r,
    output logic [BLK_PIX-1:0][7:0] buf_g,
    output logic [BLK_PIX-1:0][7:0] buf_b,
    output logic                    conv_start,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic [BLK_CNT_W-1:0]    blk_cnt
);

    state_t               state_q, state_d;
    logic [5:0]           pix_idx_q, pix_idx_d;
    logic [3:0]           lat_q, lat_d;
    logic                 conv_start_q, conv_start_d;
    logic [BLK_CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic                 wr_en;

    // Handshake flags come straight from state so they track reset at once.
    assign pix_ready  = (state_q == FILL);
    assign blk_valid  = (state_q == HOLD);
    assign wr_en      = pix_valid && pix_ready;
    assign conv_start = conv_start_q;
    assign blk_cnt    = blk_cnt_q;

    always_comb begin
        state_d      = state_q;
        pix_idx_d    = pix_idx_q;
        lat_d        = lat_q;
        conv_start_d = 1'b0;
        blk_cnt_d    = blk_cnt_q;
        unique case (state_q)
            FILL: begin
                if (wr_en) begin
                    pix_idx_d = pix_idx_q + 6'd1;
                    if (pix_idx_q == 6'(BLK_PIX - 1)) begin
                        state_d      = CONV;
                        conv_start_d = 1'b1;
                        lat_d        = 4'd0;
                    end
                end
            end
            CONV: begin
                if (lat_q == 4'(CONV_LAT - 1)) begin
                    state_d = HOLD;
                    lat_d   = 4'd0;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            HOLD: begin
                if (blk_ready) begin
                    blk_cnt_d = blk_cnt_q + BLK_CNT_W'(1);
                    state_d   = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            pix_idx_q    <= 6'd0;
            lat_q        <= 4'd0;
            conv_start_q <= 1'b0;
            blk_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            pix_idx_q    <= pix_idx_d;
            lat_q        <= lat_d;
            conv_start_q <= conv_start_d;
            blk_cnt_q    <= blk_cnt_d;
        end
    end

    ycc_pix_buf u_buf (
        .clk (clk),
        .we  (wr_en),
        .idx (pix_idx_q),
        .din ({pix_r, pix_g, pix_b}),
        .q_r (buf_r),
        .q_g (buf_g),
        .q_b (buf_b)
    );

endmodule

// File: tb/tb_ycc_block_ctrl.sv
// Directed bench for ycc_block_ctrl with a block scoreboard:
// expected buffers queued on fill, compared at handoff.
module tb_ycc_block_ctrl;

    localparam int CONV_LAT  = 2;
    localparam int BLK_CNT_W = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 pix_valid = 1'b0;
    logic                 pix_ready;
    logic [7:0]           pix_r = 8'd0;
    logic [7:0]           pix_g = 8'd0;
    logic [7:0]           pix_b = 8'd0;
    logic [63:0][7:0]     buf_r;
    logic [63:0][7:0]     buf_g;
    logic [63:0][7:0]     buf_b;
    logic                 conv_start;
    logic                 blk_valid;
    logic                 blk_ready = 1'b0;
    logic [BLK_CNT_W-1:0] blk_cnt;

    typedef struct {
        logic [63:0][7:0] r;
        logic [63:0][7:0] g;
        logic [63:0][7:0] b;
    } blk_t;

    blk_t                 sb[$];
    int                   total = 0;
    int                   passed = 0;
    int                   cyc = 0;
    int                   feed_cycles = 0;
    int                   t_first = 0;
    logic [BLK_CNT_W-1:0] exp_cnt = '0;

    ycc_block_ctrl #(
        .CONV_LAT  (CONV_LAT),
        .BLK_CNT_W (BLK_CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_r      (pix_r),
        .pix_g      (pix_g),
        .pix_b      (pix_b),
        .buf_r      (buf_r),
        .buf_g      (buf_g),
        .buf_b      (buf_b),
        .conv_start (conv_start),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_cnt    (blk_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs,
                         input logic [511:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drive n pixels (optionally every other cycle); queue a full block.
    task automatic feed(input int seed, input bit gapped, input int n);
        blk_t e;
        int   k = 0;
        int   c = 0;
        bit   v;
        bit   rdy_ok = 1'b1;
        bit   cs = 1'b0;
        while (k < n) begin
            v = !gapped || (c % 2 == 0);
            pix_valid = v;
            pix_r = v ? 8'(k + seed) : 8'hEE;
            pix_g = v ? 8'(2 * k + seed) : 8'hEE;
            pix_b = v ? 8'(255 - k - seed) : 8'hEE;
            if (v) begin
                e.r[k] = 8'(k + seed);
                e.g[k] = 8'(2 * k + seed);
                e.b[k] = 8'(255 - k - seed);
            end
            rdy_ok &= (pix_ready === 1'b1);
            cs |= (conv_start === 1'b1);
            step();
            c++;
            if (v) k++;
        end
        pix_valid = 1'b0;
        feed_cycles = c;
        if (n == 64) begin
            sb.push_back(e);
            check("feed_ready", rdy_ok, 1'b1);
            check("feed_no_early_start", cs, 1'b0);
            check("conv_start_pulse", conv_start, 1'b1);
            check("ready_low_conv", pix_ready, 1'b0);
            check("fill_cnt_stable", blk_cnt, exp_cnt);
        end
    endtask

    // From conv_start: latency, optional stall, optional stray pixels, handoff.
    task automatic finish(input int stall, input bit stray);
        blk_t e;
        int   n;
        bit   hold_ok = 1'b1;
        blk_ready = (stall == 0);
        if (stray) begin
            pix_valid = 1'b1;
            pix_r = 8'h5A;
            pix_g = 8'hA5;
            pix_b = 8'h3C;
        end
        step();
        n = 1;
        check("conv_start_one_cycle", conv_start, 1'b0);
        while (blk_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("conv_latency", n, CONV_LAT);
        for (int i = 0; i < stall; i++) begin
            hold_ok &= (blk_valid === 1'b1) && (pix_ready === 1'b0);
            hold_ok &= (blk_cnt === exp_cnt) && (conv_start === 1'b0);
            if (sb.size() > 0) begin
                hold_ok &= (buf_r === sb[0].r) && (buf_g === sb[0].g);
                hold_ok &= (buf_b === sb[0].b);
            end
            step();
        end
        if (stall > 0) check("stall_hold", hold_ok, 1'b1);
        blk_ready = 1'b1;
        check("handoff_valid", blk_valid, 1'b1);
        check("sb_nonempty", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("buf_r", buf_r, e.r);
            check("buf_g", buf_g, e.g);
            check("buf_b", buf_b, e.b);
            check("cnt_before", blk_cnt, exp_cnt);
        end
        step();
        pix_valid = 1'b0;
        exp_cnt++;
        check("blk_cnt", blk_cnt, exp_cnt);
        check("valid_drop", blk_valid, 1'b0);
        check("ready_back", pix_ready, 1'b1);
    endtask

    initial begin
        #3;
        check("rst_ready", pix_ready, 1'b1);
        check("rst_valid", blk_valid, 1'b0);
        check("rst_start", conv_start, 1'b0);
        check("rst_cnt", blk_cnt, '0);
        #9;
        rst_n = 1'b1;
        step();

        t_first = cyc;
        feed(0, 1'b0, 64);
        finish(0, 1'b0);
        check("period", cyc - t_first, 64 + CONV_LAT + 1);
        check("buf_r10", buf_r[10], 8'd10);
        check("cnt_1", blk_cnt, 2'd1);

        feed(37, 1'b0, 64);
        finish(20, 1'b0);
        check("cnt_2", blk_cnt, 2'd2);

        feed(90, 1'b1, 64);
        check("gap_cycles", feed_cycles, 127);
        finish(0, 1'b0);
        check("cnt_3", blk_cnt, 2'd3);

        feed(150, 1'b0, 64);
        finish(0, 1'b1);
        check("cnt_wrap_0", blk_cnt, 2'd0);

        feed(200, 1'b0, 64);
        finish(0, 1'b0);
        check("cnt_wrap_1", blk_cnt, 2'd1);

        feed(100, 1'b0, 30);
        rst_n = 1'b0;
        #2;
        check("midrst_ready", pix_ready, 1'b1);
        check("midrst_valid", blk_valid, 1'b0);
        check("midrst_start", conv_start, 1'b0);
        check("midrst_cnt", blk_cnt, '0);
        step();
        step();
        rst_n = 1'b1;
        exp_cnt = '0;
        feed(7, 1'b0, 64);
        finish(0, 1'b0);
        check("after_rst_cnt", blk_cnt, 2'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ycc_block_ctrl.md
YCC_BLOCK_CTRL -- requirements
Module: ycc_block_ctrl

Interface
REQ-001 SHALL have parameter CONV_LAT, default 2: clk cycles from conversion launch until the luma converter's 8x8 output is stable; legal range 1..15.
REQ-002 SHALL have parameter BLK_CNT_W, default 16: width of the completed-block counter.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port pix_valid, input, 1: upstream has a pixel on pix_r/pix_g/pix_b.
REQ-006 SHALL have port pix_ready, output, 1: block accepts a pixel this cycle.
REQ-007 SHALL have ports pix_r, pix_g, pix_b, input, 8 each: unsigned RGB sample, raster order within the 8x8 block.
REQ-008 SHALL have ports buf_r, buf_g, buf_b, output, 64x8 each: pixel buffer driven to the converter; entry k = row k/8, column k%8.
REQ-009 SHALL have port conv_start, output, 1: one-cycle pulse marking conversion launch.
REQ-010 SHALL have port blk_valid, output, 1: converter 8x8 luma output is valid for downstream.
REQ-011 SHALL have port blk_ready, input, 1: downstream accepts the block.
REQ-012 SHALL have port blk_cnt, output, BLK_CNT_W: number of blocks handed off since reset.

Function
REQ-013 SHALL implement FSM states FILL, CONV, HOLD.
REQ-014 In FILL, pix_ready SHALL be 1; a transfer occurs when pix_valid and pix_ready are both high in the same cycle.
REQ-015 Each transfer SHALL write the pixel to buffer entry pix_idx and increment 6-bit pix_idx.
REQ-016 A transfer at pix_idx = 63 SHALL wrap pix_idx to 0, move to CONV, and assert conv_start for exactly the next cycle.
REQ-017 In CONV, a latency counter SHALL count CONV_LAT cycles starting with the conv_start cycle, then move to HOLD.
REQ-018 In HOLD, blk_valid SHALL be 1 and remain 1 until blk_ready is sampled high.
REQ-019 On blk_valid and blk_ready both high, the block SHALL increment blk_cnt, with modulo 2^BLK_CNT_W wrap, and return to FILL on the next cycle.
REQ-020 pix_ready SHALL be 0 in CONV and HOLD, because the converter re-samples its inputs every cycle; buf_* SHALL stay unchanged from the 64th write until handoff.
REQ-021 blk_ready asserted outside HOLD SHALL be ignored.
REQ-022 pix_valid outside FILL SHALL NOT write the buffer or advance pix_idx.
REQ-023 Minimum period from the first pixel to the next first pixel SHALL be 64 + CONV_LAT + 1 cycles with blk_ready held high.
REQ-024 All outputs SHALL be registered except pix_ready and blk_valid, which SHALL be decoded directly from state.

Reset
REQ-025 Asserting rst_n low SHALL force the following immediately, at any state including mid-fill or in HOLD: state FILL, pix_idx 0, latency counter 0, conv_start 0, blk_cnt 0.
REQ-026 While rst_n is low, pix_ready SHALL read 1, since state is FILL, and blk_valid SHALL read 0.
REQ-027 Buffer contents SHALL NOT be reset; they are don't-care until the first 64 writes complete.
REQ-028 A partial block interrupted by reset SHALL be discarded and SHALL NOT count toward blk_cnt.

Structure
REQ-029 A shared package SHALL hold: the state enum {FILL, CONV, HOLD}, the constant BLK_PIX = 64, and the pixel type of 8 unsigned bits.
REQ-030 The pixel buffer SHALL be one sub-module, ycc_pix_buf: 64x24-bit storage with write enable and index, exposing all entries in parallel.
REQ-031 The controller SHALL NOT instantiate the converter; the integration level connects buf_* to the converter and blk_valid/blk_ready to the consumer.

Verification
REQ-032 The bench SHALL cover a single block: 64 pixels with R=k, G=2k, B=255-k, pix_valid always high, blk_ready high -> conv_start at cycle 65, blk_valid for 1 cycle at cycle 65+CONV_LAT, buf_r[10]=10, blk_cnt=1.
REQ-033 The bench SHALL cover backpressure: blk_ready low for 20 cycles in HOLD -> blk_valid held 20 cycles, pix_ready 0 throughout, buf_* unchanged, blk_cnt increments only on the release cycle.
REQ-034 The bench SHALL cover gapped input: pix_valid toggling 1/0 -> exactly 64 writes over 127 cycles, then a single conv_start, with no write on the low cycles.
REQ-035 The bench SHALL cover reset mid-fill: rst_n low after 30 pixels, then 64 new pixels -> the first block contains only the new pixels and blk_cnt=1 after handoff.
REQ-036 The bench SHALL cover the counter wrap: BLK_CNT_W=2, 5 blocks -> blk_cnt sequence 1,2,3,0,1.
REQ-037 The bench SHALL cover stray handshakes: pix_valid high during CONV/HOLD and blk_ready high during FILL -> no buffer change, no state change, no blk_cnt change.
